// File: rtl/cc_reg.sv
// rtl/cc_reg.sv - Y86-64 SEQ condition-code register with jXX/cmovXX condition decode
// Optional CC_BYPASS_EN forwards the flags being written into cnd within the same cycle.
module cc_reg #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         set_cc,
    input  logic [3:0]   alu_fun,
    input  logic [W-1:0] alu_a,
    input  logic [W-1:0] alu_b,
    input  logic [W-1:0] alu_e,
    input  logic [3:0]   cond_fun,
    output logic         zf,
    output logic         sf,
    output logic         of,
    output logic         cnd,
    output logic         cc_err
);

    logic r_zf;
    logic r_sf;
    logic r_of;
    logic r_cc_err;

    logic w_zf_n;
    logic w_sf_n;
    logic w_of_n;
    logic w_fun_ok;
    logic w_update;
    logic w_unused;

    function automatic logic f_cond(input logic [3:0] cf, input logic z, input logic s, input logic o);
        logic lt;
        lt = s ^ o;
        case (cf)
            4'd0:    f_cond = 1'b1;
            4'd1:    f_cond = lt | z;
            4'd2:    f_cond = lt;
            4'd3:    f_cond = z;
            4'd4:    f_cond = ~z;
            4'd5:    f_cond = ~lt;
            4'd6:    f_cond = ~lt & ~z;
            default: f_cond = 1'b0;
        endcase
    endfunction

    assign w_zf_n = (alu_e == '0);
    assign w_sf_n = alu_e[W-1];

    // Overflow comes from sign bits only; the sum itself is never recomputed.
    always_comb begin
        w_of_n = 1'b0;
        case (alu_fun)
            4'd0:    w_of_n = (alu_a[W-1] == alu_b[W-1]) && (alu_e[W-1] != alu_a[W-1]);
            4'd1:    w_of_n = (alu_a[W-1] != alu_b[W-1]) && (alu_e[W-1] != alu_b[W-1]);
            default: w_of_n = 1'b0;
        endcase
    end

    assign w_fun_ok = (alu_fun <= 4'd3);
    assign w_update = ~rst & en & set_cc & w_fun_ok;
    assign w_unused = &{1'b0, alu_a[W-2:0], alu_b[W-2:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_zf     <= 1'b1;
            r_sf     <= 1'b0;
            r_of     <= 1'b0;
            r_cc_err <= 1'b0;
        end else if (en) begin
            r_cc_err <= set_cc & ~w_fun_ok;
            if (w_update) begin
                r_zf <= w_zf_n;
                r_sf <= w_sf_n;
                r_of <= w_of_n;
            end
        end
    end

    assign zf     = r_zf;
    assign sf     = r_sf;
    assign of     = r_of;
    assign cc_err = r_cc_err;

`ifdef CC_BYPASS_EN
    assign cnd = w_update ? f_cond(cond_fun, w_zf_n, w_sf_n, w_of_n)
                          : f_cond(cond_fun, r_zf, r_sf, r_of);
`else
    assign cnd = f_cond(cond_fun, r_zf, r_sf, r_of);
`endif

endmodule
